freelist: RTL and testbench
===========================

# freelist

Physical-register free list for the rename stage of the out-of-order core. Holds the physical registers not currently mapped by any architectural register, hands one out per cycle to rename, takes back one per cycle from commit, and drives `freelist_empty` to the hazard unit. A committed read pointer lets the speculative head roll back on a pipeline flush.

## Interface

- Clocking: one clock; reset is synchronous and active-low.
- Parameters:
  - `NUM_PREG`, default 64: number of physical registers.
  - `NUM_AREG`, default 32: number of architectural registers.
  - `DEPTH = NUM_PREG - NUM_AREG` (derived): capacity of the free list. Must be a power of two; default 32.
- Ports:
  - `clk`, in, 1: clock.
  - `rst_n`, in, 1: synchronous active-low reset.
  - `alloc_en`, in, 1: rename consumes the head entry this cycle.
  - `alloc_preg`, out, $clog2(NUM_PREG): physical register at the speculative head.
  - `release_en`, in, 1: commit returns a physical register.
  - `release_preg`, in, $clog2(NUM_PREG): register being returned.
  - `commit_alloc_en`, in, 1: a committing instruction had allocated a register; advance the committed head.
  - `flush`, in, 1: restore the speculative head to the committed head.
  - `freelist_empty`, out, 1: no free entries.
  - `free_count`, out, $clog2(DEPTH)+1: number of free entries.
  - `freelist_err`, out, 1: sticky error flag (see Configuration).

## Operation

- Storage: circular buffer of `DEPTH` entries.
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - `head`: speculative read pointer.
  - `commit_head`: committed read pointer.
  - `tail`: write pointer.
- `free_count = tail - head`, modulo 2^(ptr width). `freelist_empty = (free_count == 0)`.
- Reset state:
  - Entry i = `NUM_AREG + i`.
  - `head = commit_head = 0`, `tail = DEPTH` (wrap bit set, index 0).
  - Resulting outputs: `free_count = DEPTH`, `freelist_empty = 0`, `alloc_preg = NUM_AREG`, `freelist_err = 0`.
  - Physical registers 0..NUM_AREG-1 are never in the list at reset.
- Allocate:
  - When `alloc_en && !freelist_empty && !flush`: `head <= head + 1`.
  - `alloc_en` while empty is ignored; the head does not move.
- Release:
  - When `release_en`: `buf[tail] <= release_preg`, `tail <= tail + 1`.
  - Release is always accepted; release while `free_count == DEPTH` is an overflow (see Configuration).
- Commit: when `commit_alloc_en`, `commit_head <= commit_head + 1`.
- Flush:
  - `head <= commit_head_next`, i.e. `commit_head` after this cycle's commit increment.
  - `alloc_en` is ignored in the flush cycle.
  - Release and commit in the same cycle are applied normally.
- Simultaneous allocate and release:
  - Both pointers advance; `free_count` is unchanged.
  - When empty, only the release takes effect: the allocate is ignored and `free_count` becomes 1.

## Timing

- `alloc_preg`, `freelist_empty` and `free_count` are combinational from registered pointers and storage. There are no comb paths from any input.
- Allocation latency is 0: `alloc_preg` is valid in the same cycle `alloc_en` is sampled, whenever `!freelist_empty`.
- A released register becomes visible one cycle later: `free_count` increments at the next edge. If it lands at the head, it is readable on `alloc_preg` in the next cycle.
- A flush takes effect at the next edge. `free_count` reflects the restored head in the following cycle.
- `rst_n` low at any edge reinitialises all state, regardless of other inputs, including mid-flush.

## Configuration

- `FREELIST_CHECK_EN`
  - Defined:
    - Add a `NUM_PREG`-bit in-list bitmap, reset to ones for `NUM_AREG..NUM_PREG-1`.
    - Release of a register already in the list, release of preg 0, release overflow, or `alloc_en` while empty sets `freelist_err`. The flag is sticky until reset.
    - On an erroneous release, the write and the tail advance are suppressed.
    - Allocate clears the register's bit; release sets it.
    - On flush, the bitmap is rebuilt as the bits of `buf[commit_head_next .. tail_next)`: an iterative loop, one cycle, acceptable area.
  - Undefined:
    - No bitmap; `freelist_err` is tied to 0.
    - Erroneous releases are written as normal.

## Test plan

- Reset, then 32 back-to-back `alloc_en`:
  - `alloc_preg` sequence is 32..63.
  - `free_count` goes 32→0.
  - `freelist_empty` = 1 after the 32nd allocate.
  - A 33rd `alloc_en` leaves the head unchanged.
- Empty list, `alloc_en` and `release_en` (preg 40) in the same cycle:
  - Next cycle: `free_count = 1`, `alloc_preg = 40`, `freelist_empty = 0`.
- Allocate 5 (32..36), commit 2, flush:
  - Two cycles later: `alloc_preg = 34`, `free_count = 30`.
- Flush in the same cycle as `commit_alloc_en` and `release_en` (preg 33), after 3 allocates and 1 prior commit:
  - The head restores to committed+1.
  - The tail advances and `buf[old tail] = 33`.
- Wrap-around: 40 cycles of concurrent allocate and release with pregs 1..40.
  - `free_count` stays 32.
  - Allocations return 32..63 followed by 1..8 in order.
- With `FREELIST_CHECK_EN` defined:
  - Release preg 50 while it is still free → `freelist_err = 1` next cycle; `free_count` is unchanged.
  - The flag holds until `rst_n` is asserted low.

Source files
------------

// File: rtl/freelist.sv
// Physical-register free list with speculative and committed read pointers.
// Define FREELIST_CHECK_EN to add the in-list bitmap and sticky freelist_err.
module freelist #(
    parameter  int NUM_PREG = 64,
    parameter  int NUM_AREG = 32,
    localparam int DEPTH    = NUM_PREG - NUM_AREG,
    localparam int PW       = $clog2(NUM_PREG),
    localparam int IW       = $clog2(DEPTH),
    localparam int CW       = IW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc_en,
    output logic [PW-1:0] alloc_preg,
    input  logic          release_en,
    input  logic [PW-1:0] release_preg,
    input  logic          commit_alloc_en,
    input  logic          flush,
    output logic          freelist_empty,
    output logic [CW-1:0] free_count,
    output logic          freelist_err
);

    logic [PW-1:0] mem [DEPTH];
    logic [CW-1:0] head;
    logic [CW-1:0] commit_head;
    logic [CW-1:0] tail;
    logic [CW-1:0] head_next;
    logic [CW-1:0] commit_head_next;
    logic [CW-1:0] tail_next;
    logic          do_alloc;
    logic          do_write;

    assign free_count       = tail - head;
    assign freelist_empty   = (free_count == '0);
    assign alloc_preg       = mem[head[IW-1:0]];
    assign do_alloc         = alloc_en && !freelist_empty && !flush;
    assign commit_head_next = commit_head + CW'(commit_alloc_en);
    assign tail_next        = tail + CW'(do_write);
    assign head_next        = flush ? commit_head_next
                                    : head + CW'(do_alloc);

`ifdef FREELIST_CHECK_EN
    logic [NUM_PREG-1:0] in_list;
    logic [NUM_PREG-1:0] in_list_next;
    logic [CW-1:0]       span;
    logic [CW-1:0]       ptr;
    logic [PW-1:0]       entry;
    logic                rel_err;
    logic                err_q;

    assign rel_err = release_en &&
                     (in_list[release_preg] ||
                      release_preg == '0 ||
                      free_count == CW'(DEPTH));
    assign do_write     = release_en && !rel_err;
    assign freelist_err = err_q;
    assign span         = tail_next - commit_head_next;

    // Flush rebuilds membership from the committed head up to the new tail.
    always_comb begin
        in_list_next = in_list;
        ptr          = '0;
        entry        = '0;
        if (flush) begin
            in_list_next = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ptr   = commit_head_next + CW'(i);
                entry = (do_write && ptr == tail) ? release_preg
                                                  : mem[ptr[IW-1:0]];
                if (CW'(i) < span) begin
                    in_list_next[entry] = 1'b1;
                end
            end
        end else begin
            if (do_alloc) begin
                in_list_next[alloc_preg] = 1'b0;
            end
            if (do_write) begin
                in_list_next[release_preg] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            for (int i = 0; i < NUM_PREG; i++) begin
                in_list[i] <= (i >= NUM_AREG);
            end
        end else begin
            err_q   <= err_q | rel_err | (alloc_en && freelist_empty);
            in_list <= in_list_next;
        end
    end
`else
    assign do_write     = release_en;
    assign freelist_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head        <= '0;
            commit_head <= '0;
            tail        <= CW'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PW'(NUM_AREG + i);
            end
        end else begin
            head        <= head_next;
            commit_head <= commit_head_next;
            tail        <= tail_next;
            if (do_write) begin
                mem[tail[IW-1:0]] <= release_preg;
            end
        end
    end

endmodule

// File: tb/tb_freelist.sv
// Scoreboard bench for freelist: a queue-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_freelist;

    localparam int DEPTH = 32;

`ifdef FREELIST_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef struct {
        int preg;
        int cnt;
        int empty;
        int err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_en = 1'b0;
    logic [5:0] alloc_preg;
    logic       release_en = 1'b0;
    logic [5:0] release_preg = '0;
    logic       commit_alloc_en = 1'b0;
    logic       flush = 1'b0;
    logic       freelist_empty;
    logic [5:0] free_count;
    logic       freelist_err;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    // Model: spec_q is the free list from the speculative head, log_q holds
    // speculatively allocated registers not yet committed.
    int spec_q[$];
    int log_q[$];
    int pool_q[$];
    bit merr;

    freelist dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_en        (alloc_en),
        .alloc_preg      (alloc_preg),
        .release_en      (release_en),
        .release_preg    (release_preg),
        .commit_alloc_en (commit_alloc_en),
        .flush           (flush),
        .freelist_empty  (freelist_empty),
        .free_count      (free_count),
        .freelist_err    (freelist_err)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        spec_q = {};
        log_q  = {};
        pool_q = {};
        for (int i = 32; i < 64; i++) spec_q.push_back(i);
        for (int i = 1; i < 32; i++) pool_q.push_back(i);
        merr = 1'b0;
    endfunction

    function automatic bit in_spec(int p);
        foreach (spec_q[i]) if (spec_q[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_update(bit a, bit r, int rp,
                                         bit c, bit f);
        int pre;
        bit rel_ok;
        pre    = spec_q.size();
        rel_ok = r;
        if (CHECK) begin
            if (r && (rp == 0 || pre == DEPTH || in_spec(rp))) begin
                merr   = 1'b1;
                rel_ok = 1'b0;
            end
            if (a && pre == 0) merr = 1'b1;
        end
        if (c && log_q.size() > 0) pool_q.push_back(log_q.pop_front());
        if (!f && a && pre > 0) log_q.push_back(spec_q.pop_front());
        if (rel_ok) spec_q.push_back(rp);
        if (f) begin
            spec_q = {log_q, spec_q};
            log_q  = {};
        end
    endfunction

    function automatic void push_model();
        exp_t e;
        e.cnt   = spec_q.size();
        e.empty = (spec_q.size() == 0);
        e.preg  = e.empty ? 0 : spec_q[0];
        e.err   = merr;
        sb.push_back(e);
    endfunction

    task automatic step(input bit a, input bit r, input int rp,
                        input bit c, input bit f);
        @(posedge clk);
        #1;
        push_model();
        alloc_en        = a;
        release_en      = r;
        release_preg    = 6'(rp);
        commit_alloc_en = c;
        flush           = f;
        model_update(a, r, rp, c, f);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Reset is held with activity on the inputs, including a flush.
    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = 1'b0;
        alloc_en        = 1'b1;
        release_en      = 1'b1;
        release_preg    = 6'd5;
        commit_alloc_en = 1'b1;
        flush           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n           = 1'b1;
        alloc_en        = 1'b0;
        release_en      = 1'b0;
        commit_alloc_en = 1'b0;
        flush           = 1'b0;
        model_reset();
        e.preg  = 32;
        e.cnt   = 32;
        e.empty = 0;
        e.err   = 0;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("free_count", int'(free_count), e.cnt);
                check("freelist_empty", int'(freelist_empty), e.empty);
                check("freelist_err", int'(freelist_err), e.err);
                if (e.empty == 0) begin
                    check("alloc_preg", int'(alloc_preg), e.preg);
                end
            end
        end
    end

    initial begin : stimulus
        int idx;
        int rp;
        bit a;
        bit r;
        bit c;
        bit f;

        // Drain the list completely, then one allocate beyond empty.
        do_reset();
        for (int i = 0; i < 33; i++) step(1, 0, 0, 0, 0);
        // Allocate and release on an empty list.
        step(1, 1, 40, 0, 0);
        idle(2);

        // Allocate five, commit two, flush.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        idle(3);

        // Flush together with commit and release after three allocates.
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        step(0, 1, 33, 1, 1);
        for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0);
        idle(1);

        // Wrap-around with concurrent allocate and release.
        do_reset();
        for (int i = 1; i <= 40; i++) step(1, 1, i, 0, 0);
        for (int i = 0; i < 34; i++) step(1, 0, 0, 0, 0);
        idle(1);

`ifdef FREELIST_CHECK_EN
        // Duplicate release of a free register sets the sticky flag.
        do_reset();
        step(0, 1, 50, 0, 0);
        idle(4);
        step(0, 1, 0, 0, 0);
        idle(2);
`endif

        // Randomized legal traffic.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            a = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 19) == 0);
            c = (log_q.size() > 0) && ($urandom_range(0, 1) == 1);
            r = (pool_q.size() > 0) &&
                (spec_q.size() + log_q.size() < DEPTH) &&
                ($urandom_range(0, 1) == 1);
            rp = 0;
            if (r) begin
                idx = $urandom_range(0, pool_q.size() - 1);
                rp  = pool_q[idx];
                pool_q.delete(idx);
            end
            step(a, r, rp, c, f);
        end
        idle(3);

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
